// File: rtl/wb_pkg.sv
// Shared writeback types: load funct3 encodings, the pending-load descriptor
// and the write-source select enum.
// The register index inside a descriptor is RD_W bits wide, so the writeback
// unit must be built with mem_depth <= 32.
package wb_pkg;

  localparam int unsigned RD_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [2:0]      funct3;
    logic [1:0]      offset;
  } ld_desc_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_SKID,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle: ALU path, load issue/response, hazard query and
// register-file drive. master = upstream/pipeline side, slave = writeback_unit.
// With WB_BYPASS_EN defined the bundle also carries byp_valid/byp_addr/byp_data.
interface writeback_unit_if #(
  parameter int unsigned mem_width = 32,
  parameter int unsigned mem_depth = 32
);
  localparam int unsigned RW = $clog2(mem_depth);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [RW-1:0]        alu_rd;
  logic [mem_width-1:0] alu_result;

  logic                 ld_issue;
  logic                 ld_ready;
  logic [RW-1:0]        ld_rd;
  logic [2:0]           ld_funct3;
  logic [1:0]           ld_offset;

  logic                 mem_rvalid;
  logic [mem_width-1:0] mem_rdata;
  logic                 ld_err;

  logic [RW-1:0]        rs1;
  logic [RW-1:0]        rs2;
  logic [RW-1:0]        rd_chk;
  logic                 hazard;

  logic                 rf_we;
  logic [RW-1:0]        rf_addr;
  logic [mem_width-1:0] rf_data;

`ifdef WB_BYPASS_EN
  logic                 byp_valid;
  logic [RW-1:0]        byp_addr;
  logic [mem_width-1:0] byp_data;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    input  byp_valid, byp_addr, byp_data,
`endif
    output alu_valid, alu_rd, alu_result,
    output ld_issue, ld_rd, ld_funct3, ld_offset,
    output mem_rvalid, mem_rdata,
    output rs1, rs2, rd_chk,
    input  alu_ready, ld_ready, ld_err, hazard,
    input  rf_we, rf_addr, rf_data
  );

  modport slave (
`ifdef WB_BYPASS_EN
    output byp_valid, byp_addr, byp_data,
`endif
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue, ld_rd, ld_funct3, ld_offset,
    input  mem_rvalid, mem_rdata,
    input  rs1, rs2, rd_chk,
    output alu_ready, ld_ready, ld_err, hazard,
    output rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/wb_load_fifo.sv
// Pending-load descriptor FIFO.
// Ports: clk, reset (async, active-high); push/din write side; pop/head read
// side; full/empty status; entry_rd/entry_valid expose every slot for hazard
// lookup. Pointers carry one extra wrap bit to tell full from empty.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  ld_desc_t                   din,
  input  logic                       pop,
  output ld_desc_t                   head,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0][RD_W-1:0] entry_rd,
  output logic [DEPTH-1:0]           entry_valid
);
  localparam int unsigned AW = $clog2(DEPTH);

  ld_desc_t [DEPTH-1:0] mem;
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [AW:0]          count;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // A slot is live when its distance from the read pointer is below the fill count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign entry_rd[g]    = mem[g].rd;
    assign entry_valid[g] = {1'b0, AW'(g) - rd_ptr[AW-1:0]} < count;
  end

  // Storage needs no reset: only slots flagged valid are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: merges load responses, a one-entry ALU
// skid and the ALU input into one registered write per cycle
// (priority load > skid > ALU), formats load data, tracks pending loads and
// flags register hazards.
// Ports: clk, reset (async, active-high), wb (writeback_unit_if.slave).
// Optional macro WB_BYPASS_EN: drives byp_* with the write selected this cycle.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned mem_width = 32,
  parameter int unsigned mem_depth = 32,
  parameter int unsigned LQ_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  writeback_unit_if.slave  wb
);
  localparam int unsigned RW = $clog2(mem_depth);

  ld_desc_t                     push_desc;
  ld_desc_t                     head;
  logic                         full, empty, push, pop;
  logic [LQ_DEPTH-1:0][RD_W-1:0] entry_rd;
  logic [LQ_DEPTH-1:0]          entry_valid;

  logic                 skid_full;
  logic [RW-1:0]        skid_rd;
  logic [mem_width-1:0] skid_data;
  logic                 alu_accept;

  wb_src_e              src;
  logic [RW-1:0]        sel_rd;
  logic [mem_width-1:0] sel_data;
  logic                 sel_we;
  logic [mem_width-1:0] ld_data;
  logic                 fmt_bad;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic                 hazard_c;

  // An issue on a full queue is dropped even if a pop frees a slot this cycle.
  assign push       = wb.ld_issue & ~full;
  assign pop        = wb.mem_rvalid & ~empty;
  assign alu_accept = wb.alu_valid & ~skid_full;
  assign push_desc  = '{rd: RD_W'(wb.ld_rd), funct3: wb.ld_funct3, offset: wb.ld_offset};

  assign wb.ld_ready  = ~full;
  assign wb.alu_ready = ~skid_full;

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .din         (push_desc),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // Load data extraction for the descriptor at the queue head.
  always_comb begin
    ld_data = '0;
    fmt_bad = 1'b0;
    ld_byte = wb.mem_rdata[{head.offset, 3'b000} +: 8];
    ld_half = head.offset[1] ? wb.mem_rdata[16 +: 16] : wb.mem_rdata[0 +: 16];
    case (head.funct3)
      F3_LB:   ld_data = {{(mem_width-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(mem_width-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data = wb.mem_rdata;
      F3_LBU:  ld_data = mem_width'(ld_byte);
      F3_LHU:  ld_data = mem_width'(ld_half);
      default: fmt_bad = 1'b1;
    endcase
  end

  // Write-source arbitration.
  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (pop)             src = SRC_LOAD;
    else if (skid_full)  src = SRC_SKID;
    else if (alu_accept) src = SRC_ALU;
    case (src)
      SRC_LOAD: begin sel_rd = RW'(head.rd); sel_data = ld_data;       end
      SRC_SKID: begin sel_rd = skid_rd;      sel_data = skid_data;     end
      SRC_ALU:  begin sel_rd = wb.alu_rd;    sel_data = wb.alu_result; end
      default:  ;
    endcase
    sel_we = (src != SRC_NONE) && (sel_rd != '0);
  end

  function automatic logic rd_hit(input logic [RW-1:0] rd, input logic [RW-1:0] a,
                                  input logic [RW-1:0] b, input logic [RW-1:0] c);
    return (rd != '0) && ((rd == a) || (rd == b) || (rd == c));
  endfunction

  // Hazard against any pending load destination or the parked ALU result.
  always_comb begin
    hazard_c = skid_full && rd_hit(skid_rd, wb.rs1, wb.rs2, wb.rd_chk);
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (entry_valid[i] && rd_hit(RW'(entry_rd[i]), wb.rs1, wb.rs2, wb.rd_chk))
        hazard_c = 1'b1;
    end
  end
  assign wb.hazard = hazard_c;

`ifdef WB_BYPASS_EN
  assign wb.byp_valid = sel_we;
  assign wb.byp_addr  = sel_rd;
  assign wb.byp_data  = sel_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_full  <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
      wb.ld_err  <= 1'b0;
      wb.rf_we   <= 1'b0;
      wb.rf_addr <= '0;
      wb.rf_data <= '0;
    end else begin
      wb.rf_we   <= sel_we;
      wb.rf_addr <= sel_rd;
      wb.rf_data <= sel_data;
      // An accepted ALU beat parks only when a load response takes the port.
      if (pop && alu_accept) begin
        skid_full <= 1'b1;
        skid_rd   <= wb.alu_rd;
        skid_data <= wb.alu_result;
      end else if (skid_full && !pop) begin
        skid_full <= 1'b0;
      end
      if ((wb.mem_rvalid && empty) || (pop && fmt_bad)) wb.ld_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a vector table of single-cycle
// transactions plus hand sequences for collision, full queue, reset and errors.
module tb_writeback_unit;
  import wb_pkg::*;

  logic clk;
  logic reset;

  writeback_unit_if #(.mem_width(32), .mem_depth(32)) wb ();

  writeback_unit #(.mem_width(32), .mem_depth(32), .LQ_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ares;
    logic        li;
    logic [4:0]  lrd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        mv;
    logic [31:0] md;
    logic        we;
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t v_none();
    vec_t t;
    t = '{av: 1'b0, ard: 5'd0, ares: 32'h0, li: 1'b0, lrd: 5'd0, f3: 3'd0, off: 2'd0,
          mv: 1'b0, md: 32'h0, we: 1'b0, chk: 1'b0, addr: 5'd0, data: 32'h0};
    return t;
  endfunction

  function automatic vec_t v_alu(input logic [4:0] rd, input logic [31:0] res, input logic we);
    vec_t t = v_none();
    t.av = 1'b1; t.ard = rd; t.ares = res;
    t.we = we; t.chk = we; t.addr = rd; t.data = res;
    return t;
  endfunction

  function automatic vec_t v_iss(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    vec_t t = v_none();
    t.li = 1'b1; t.lrd = rd; t.f3 = f3; t.off = off;
    return t;
  endfunction

  function automatic vec_t v_rsp(input logic [31:0] md, input logic we,
                                 input logic [4:0] addr, input logic [31:0] data);
    vec_t t = v_none();
    t.mv = 1'b1; t.md = md;
    t.we = we; t.chk = we; t.addr = addr; t.data = data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_result = '0;
    wb.ld_issue = 1'b0; wb.ld_rd = '0; wb.ld_funct3 = '0; wb.ld_offset = '0;
    wb.mem_rvalid = 1'b0; wb.mem_rdata = '0;
    wb.rs1 = '0; wb.rs2 = '0; wb.rd_chk = '0;
  endtask

  task automatic drive(input vec_t v);
    idle();
    wb.alu_valid = v.av; wb.alu_rd = v.ard; wb.alu_result = v.ares;
    wb.ld_issue = v.li; wb.ld_rd = v.lrd; wb.ld_funct3 = v.f3; wb.ld_offset = v.off;
    wb.mem_rvalid = v.mv; wb.mem_rdata = v.md;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string name, input logic [4:0] addr, input logic [31:0] data);
    chk({name, ".rf_we"},   32'(wb.rf_we), 32'(1'b1));
    chk({name, ".rf_addr"}, 32'(wb.rf_addr), 32'(addr));
    chk({name, ".rf_data"}, wb.rf_data, data);
  endtask

  initial begin
    tbl[0]  = v_alu(5'd5, 32'h0000_1234, 1'b1);
    tbl[1]  = v_alu(5'd0, 32'h0000_DEAD, 1'b0);
    tbl[2]  = v_iss(5'd7, F3_LB, 2'd2);
    tbl[3]  = v_rsp(32'h0080_0000, 1'b1, 5'd7, 32'hFFFF_FF80);
    tbl[4]  = v_iss(5'd7, F3_LBU, 2'd2);
    tbl[5]  = v_rsp(32'h0080_0000, 1'b1, 5'd7, 32'h0000_0080);
    tbl[6]  = v_iss(5'd9, F3_LH, 2'd2);
    tbl[7]  = v_rsp(32'h8001_1234, 1'b1, 5'd9, 32'hFFFF_8001);
    tbl[8]  = v_iss(5'd10, F3_LHU, 2'd0);
    tbl[9]  = v_rsp(32'h8001_F00D, 1'b1, 5'd10, 32'h0000_F00D);
    tbl[10] = v_iss(5'd11, F3_LW, 2'd0);
    tbl[11] = v_rsp(32'hCAFE_BABE, 1'b1, 5'd11, 32'hCAFE_BABE);
    tbl[12] = v_iss(5'd13, F3_LB, 2'd3);
    tbl[13] = v_rsp(32'h8100_0000, 1'b1, 5'd13, 32'hFFFF_FF81);
    tbl[14] = v_iss(5'd14, F3_LHU, 2'd2);
    tbl[14].av = 1'b1; tbl[14].ard = 5'd6; tbl[14].ares = 32'h42;
    tbl[14].we = 1'b1; tbl[14].chk = 1'b1; tbl[14].addr = 5'd6; tbl[14].data = 32'h42;
    tbl[15] = v_rsp(32'hABCD_0000, 1'b1, 5'd14, 32'h0000_ABCD);
    tbl[16] = v_iss(5'd0, F3_LW, 2'd0);
    tbl[17] = v_rsp(32'h0000_0055, 1'b0, 5'd0, 32'h0);
    tbl[18] = v_iss(5'd12, F3_LB, 2'd1);
    tbl[19] = v_rsp(32'h0000_7F00, 1'b1, 5'd12, 32'h0000_007F);

    // Reset state
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rf_we",   32'(wb.rf_we), 32'(1'b0));
    chk("rst.rf_addr", 32'(wb.rf_addr), 32'(5'd0));
    chk("rst.rf_data", wb.rf_data, 32'h0);
    chk("rst.ld_err",  32'(wb.ld_err), 32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    after_edge();
    chk("rel.alu_ready", 32'(wb.alu_ready), 32'(1'b1));
    chk("rel.ld_ready",  32'(wb.ld_ready), 32'(1'b1));
    chk("rel.rf_we",     32'(wb.rf_we), 32'(1'b0));

    // Table vectors: one transaction per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.alu_ready", i), 32'(wb.alu_ready), 32'(1'b1));
      chk($sformatf("v%0d.ld_ready", i),  32'(wb.ld_ready), 32'(1'b1));
`ifdef WB_BYPASS_EN
      chk($sformatf("v%0d.byp_valid", i), 32'(wb.byp_valid), 32'(tbl[i].we));
      if (tbl[i].chk) chk($sformatf("v%0d.byp_data", i), wb.byp_data, tbl[i].data);
`endif
      after_edge();
      chk($sformatf("v%0d.rf_we", i), 32'(wb.rf_we), 32'(tbl[i].we));
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.rf_addr", i), 32'(wb.rf_addr), 32'(tbl[i].addr));
        chk($sformatf("v%0d.rf_data", i), wb.rf_data, tbl[i].data);
      end
      chk($sformatf("v%0d.ld_err", i), 32'(wb.ld_err), 32'(1'b0));
    end

    // Collision: load response and ALU beat in the same cycle
    @(negedge clk); drive(v_iss(5'd3, F3_LW, 2'd0));
    after_edge();
    @(negedge clk);
    idle();
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'h1111_1111;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd4; wb.alu_result = 32'h2222_2222;
    #1;
    chk("col.alu_ready_pre", 32'(wb.alu_ready), 32'(1'b1));
    after_edge();
    chk_wr("col.load", 5'd3, 32'h1111_1111);
    chk("col.alu_ready_mid", 32'(wb.alu_ready), 32'(1'b0));
    @(negedge clk);
    idle();
    wb.rs2 = 5'd4;
    #1;
    chk("col.skid_hazard", 32'(wb.hazard), 32'(1'b1));
    after_edge();
    chk_wr("col.alu", 5'd4, 32'h2222_2222);
    chk("col.alu_ready_post", 32'(wb.alu_ready), 32'(1'b1));
    chk("col.hazard_clear", 32'(wb.hazard), 32'(1'b0));

    // Fill the queue with rd 1..4
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); drive(v_iss(5'(k), F3_LW, 2'd0));
      after_edge();
    end
    chk("full.ld_ready", 32'(wb.ld_ready), 32'(1'b0));
    @(negedge clk);
    idle();
    wb.rs1 = 5'd3;
    #1 chk("full.hazard_rs1", 32'(wb.hazard), 32'(1'b1));
    wb.rs1 = 5'd0; wb.rd_chk = 5'd4;
    #1 chk("full.hazard_rdchk", 32'(wb.hazard), 32'(1'b1));
    wb.rd_chk = 5'd0; wb.rs2 = 5'd7;
    #1 chk("full.hazard_miss", 32'(wb.hazard), 32'(1'b0));
    // Drain; the issue of rd 20 alongside the first pop must be dropped
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(v_rsp(32'h100 + 32'(k), 1'b1, 5'(k), 32'h100 + 32'(k)));
      if (k == 1) begin
        wb.ld_issue = 1'b1; wb.ld_rd = 5'd20; wb.ld_funct3 = F3_LW;
      end
      after_edge();
      chk_wr($sformatf("drain%0d", k), 5'(k), 32'h100 + 32'(k));
    end
    @(negedge clk);
    idle();
    wb.rs1 = 5'd3; wb.rs2 = 5'd20;
    #1;
    chk("drain.ld_ready", 32'(wb.ld_ready), 32'(1'b1));
    chk("drain.hazard",   32'(wb.hazard), 32'(1'b0));
    chk("drain.ld_err",   32'(wb.ld_err), 32'(1'b0));

    // Reset with two loads pending
    @(negedge clk); drive(v_iss(5'd8, F3_LW, 2'd0));
    after_edge();
    @(negedge clk); drive(v_iss(5'd9, F3_LW, 2'd0));
    after_edge();
    @(negedge clk);
    idle();
    reset = 1'b1;
    wb.rs1 = 5'd8;
    #1;
    chk("mid_rst.hazard",   32'(wb.hazard), 32'(1'b0));
    chk("mid_rst.ld_ready", 32'(wb.ld_ready), 32'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    after_edge();
    chk("mid_rst.rf_we",    32'(wb.rf_we), 32'(1'b0));
    chk("mid_rst.rf_addr",  32'(wb.rf_addr), 32'(5'd0));
    chk("mid_rst.rf_data",  wb.rf_data, 32'h0);
    chk("mid_rst.alu_rdy",  32'(wb.alu_ready), 32'(1'b1));

    // Response with an empty queue: no write, sticky error
    @(negedge clk); drive(v_rsp(32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0));
    after_edge();
    chk("orphan.rf_we",  32'(wb.rf_we), 32'(1'b0));
    chk("orphan.ld_err", 32'(wb.ld_err), 32'(1'b1));
    @(negedge clk); idle();
    repeat (2) after_edge();
    chk("orphan.sticky", 32'(wb.ld_err), 32'(1'b1));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1 chk("orphan.cleared", 32'(wb.ld_err), 32'(1'b0));

    // Unsupported funct3 writes zero and flags an error
    @(negedge clk); drive(v_iss(5'd15, 3'b011, 2'd0));
    after_edge();
    @(negedge clk); drive(v_rsp(32'hFFFF_FFFF, 1'b1, 5'd15, 32'h0));
    after_edge();
    chk_wr("badf3", 5'd15, 32'h0);
    chk("badf3.ld_err", 32'(wb.ld_err), 32'(1'b1));

    @(negedge clk); idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
